systolic_seq: RTL
=================

SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 Parameter N, default 4: systolic array dimension, rows = columns = N.
REQ-002 Parameter KW, default 8: width of the k_len operand.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run one matrix job.
REQ-006 k_len  input  KW  number of input vectors to stream; sampled when start is accepted.
REQ-007 stall  input  1  freezes the sequencer while high.
REQ-008 abort  input  1  synchronous cancel of the current job.
REQ-009 mac_done  input  1  one-cycle pulse from the PE array per completed wavefront.
REQ-010 load_w  output  1  weight-load strobe to the array.
REQ-011 w_addr  output  $clog2(N)  weight row being loaded.
REQ-012 en_x  output  1  input-stream strobe.
REQ-013 x_addr  output  KW  index of the input vector being fed.
REQ-014 en_y  output  1  result-drain strobe.
REQ-015 y_row  output  $clog2(N)  result row being drained.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_W, STREAM, DRAIN, OUTPUT and FIN.
- IDLE: start=1 and k_len!=0 latch k_len and go to LOAD_W.
- start with k_len=0 is ignored.
REQ-019 LOAD_W SHALL assert load_w for N unstalled cycles with w_addr 0..N-1, then go to STREAM.
REQ-020 STREAM SHALL assert en_x for k_len unstalled cycles with x_addr 0..k_len-1, then go to DRAIN.
REQ-021 The wavefront counter SHALL count mac_done pulses in STREAM and DRAIN.
- Counter clears on entry to STREAM and saturates at 2N-1.
- Counting continues while stall=1.
REQ-022 DRAIN SHALL advance to OUTPUT in the cycle after the counter reaches 2N-1; a count already at 2N-1 on entry advances immediately.
REQ-023 OUTPUT SHALL assert en_y for N unstalled cycles with y_row 0..N-1, then go to FIN.
REQ-024 FIN SHALL assert done for exactly one cycle and return to IDLE; start in that cycle is ignored.
REQ-025 While stall=1, load_w, en_x and en_y SHALL be 0 and the address counters SHALL hold.
REQ-026 start while busy=1 SHALL be ignored with no queuing.
REQ-027 abort=1 SHALL force IDLE on the next edge with no done pulse; abort has priority over stall and start.
REQ-028 Strobes and addresses SHALL be registered, with zero added latency relative to the state register.
REQ-029 Addresses SHALL read 0 whenever their strobe is low.

Reset
REQ-030 reset low SHALL immediately force IDLE, all outputs to 0 and all counters to 0, including mid-job.

Configuration
REQ-031 With SYSTOLIC_SEQ_PERF_EN defined, the block SHALL add output perf_cycles (32 bits).
- Counts cycles with busy=1 in the current or last job.
- Clears on job acceptance and holds after done.
- Wraps at 2^32.
REQ-032 Without SYSTOLIC_SEQ_PERF_EN, the port and its logic SHALL be absent.

Structure
REQ-033 Package systolic_pkg SHALL hold the state enum, the default N, and the wavefront target 2*N-1 as a function of N.
REQ-034 The saturating mac_done counter SHALL be the sub-module wavefront_counter, with ports clk, reset, clr, inc, target, reached.

Verification
REQ-035 Nominal: N=4, start with k_len=3, mac_done pulsed every other cycle seven times.
- load_w for 4 cycles, then en_x for 3 cycles (x_addr 0,1,2).
- en_y for 4 cycles after the 7th pulse, then a single done.
REQ-036 Stall: stall=1 for 2 cycles during STREAM at x_addr=1.
- en_x low for 2 cycles, x_addr holds at 1, total job length +2 cycles.
REQ-037 Back-to-back: two jobs with a 2-cycle gap.
- Second job still requires 7 fresh mac_done pulses.
- Pulses issued before its STREAM are not counted.
REQ-038 Abort: abort in OUTPUT at y_row=2.
- Next cycle busy=0 and en_y=0; no done pulse.
- A new start is accepted afterwards.
REQ-039 Reset mid-job: reset low during DRAIN.
- All outputs 0 immediately (asynchronous).
- After release, start with k_len=1 completes normally.
REQ-040 Edge cases:
- start with k_len=0 leaves busy=0.
- start while busy is ignored.
- More than 7 mac_done pulses do not disturb the sequence.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array job sequencer.
// Holds the sequencer state encoding, the default array size and the wavefront target.
package systolic_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4,
        FIN    = 3'd5
    } state_t;

    // An N x N array emits 2N-1 wavefronts before the last result settles.
    function automatic int wavefront_target(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/wavefront_counter.sv
// Saturating count of mac_done pulses; reached flags count == target.
// Latency: reached is registered, visible the cycle after the final increment.
// Backpressure: none; clr wins over inc, increments stop at target.
module wavefront_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] target,
    output logic         reached
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != target)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign reached = (cnt_q == target);

endmodule

// File: rtl/systolic_seq.sv
// Systolic array job sequencer: weight load, input stream, drain, result output (SYSTOLIC_SEQ_PERF_EN adds perf_cycles).
// Latency: strobes/addresses are registered alongside the state, so a phase strobes in its first cycle.
// Backpressure: stall freezes phase progress and blanks strobes; abort returns to IDLE on the next edge.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 stall,
    input  logic                 abort,
    input  logic                 mac_done,
    output logic                 load_w,
    output logic [$clog2(N)-1:0] w_addr,
    output logic                 en_x,
    output logic [KW-1:0]        x_addr,
    output logic                 en_y,
    output logic [$clog2(N)-1:0] y_row,
    output logic                 busy,
    output logic                 done
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam int AW = $clog2(N);
    localparam int WW = $clog2(2 * N);
    localparam int CW = (KW > $clog2(N + 1)) ? KW : $clog2(N + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;

    logic          load_w_d, en_x_d, en_y_d, done_d;
    logic [AW-1:0] w_addr_d, y_row_d;
    logic [KW-1:0] x_addr_d;
    logic          accept;
    logic          wf_clr, wf_inc, wf_reached;

    wavefront_counter #(
        .W (WW)
    ) u_wavefront_counter (
        .clk     (clk),
        .reset   (reset),
        .clr     (wf_clr),
        .inc     (wf_inc),
        .target  (WW'(wavefront_target(N))),
        .reached (wf_reached)
    );

    // Wavefronts are counted regardless of stall, only while the array is computing.
    assign wf_inc = mac_done && ((state_q == STREAM) || (state_q == DRAIN));
    assign busy   = (state_q != IDLE);

    // cnt_q holds the number of beats already issued in the current phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        load_w_d = 1'b0;
        w_addr_d = '0;
        en_x_d   = 1'b0;
        x_addr_d = '0;
        en_y_d   = 1'b0;
        y_row_d  = '0;
        done_d   = 1'b0;
        accept   = 1'b0;
        wf_clr   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        accept  = 1'b1;
                        k_d     = k_len;
                        state_d = LOAD_W;
                        cnt_d   = '0;
                        if (!stall) begin
                            load_w_d = 1'b1;
                            cnt_d    = CW'(1);
                        end
                    end
                end
                LOAD_W: begin
                    if (!stall) begin
                        if (cnt_q < CW'(N)) begin
                            load_w_d = 1'b1;
                            w_addr_d = AW'(cnt_q);
                            cnt_d    = cnt_q + 1'b1;
                        end else begin
                            state_d = STREAM;
                            wf_clr  = 1'b1;
                            en_x_d  = 1'b1;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        if (cnt_q < CW'(k_q)) begin
                            en_x_d   = 1'b1;
                            x_addr_d = KW'(cnt_q);
                            cnt_d    = cnt_q + 1'b1;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall && wf_reached) begin
                        state_d = OUTPUT;
                        en_y_d  = 1'b1;
                        cnt_d   = CW'(1);
                    end
                end
                OUTPUT: begin
                    if (!stall) begin
                        if (cnt_q < CW'(N)) begin
                            en_y_d  = 1'b1;
                            y_row_d = AW'(cnt_q);
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            state_d = FIN;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            load_w  <= 1'b0;
            w_addr  <= '0;
            en_x    <= 1'b0;
            x_addr  <= '0;
            en_y    <= 1'b0;
            y_row   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            load_w  <= load_w_d;
            w_addr  <= w_addr_d;
            en_x    <= en_x_d;
            x_addr  <= x_addr_d;
            en_y    <= en_y_d;
            y_row   <= y_row_d;
            done    <= done_d;
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    // Acceptance happens from IDLE, so clearing and counting never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
